// File: rtl/bus_arbiter_pkg.sv
// Shared definitions for the two-master bus arbiter: FSM encoding, select
// encoding, default hold limit and the tie-breaking arbitration function.
package bus_arbiter_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_OWN_M1 = 2'd1;
  localparam logic [1:0] ST_OWN_M2 = 2'd2;
  localparam logic [1:0] ST_TURN   = 2'd3;

  localparam logic SEL_M1 = 1'b0;
  localparam logic SEL_M2 = 1'b1;

  localparam int DEFAULT_MAX_HOLD  = 16;
  localparam int DEFAULT_CNT_WIDTH = 5;

  // A tie goes to whichever master did not own the bus last.
  function automatic logic [1:0] arbitrate(input logic req1, input logic req2,
                                           input logic last_owner);
    logic [1:0] nxt;
    if (req1 && req2) begin
      nxt = (last_owner == SEL_M1) ? ST_OWN_M2 : ST_OWN_M1;
    end else if (req1) begin
      nxt = ST_OWN_M1;
    end else if (req2) begin
      nxt = ST_OWN_M2;
    end else begin
      nxt = ST_IDLE;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/bus_arbiter_if.sv
// Request/grant bundle between the two masters and the arbiter.
interface bus_arbiter_if;
  logic req_m1;
  logic req_m2;
  logic grant_m1;
  logic grant_m2;
  logic master_select;
  logic bus_busy;
  logic preempt;

  modport master (
    output req_m1, req_m2,
    input  grant_m1, grant_m2, master_select, bus_busy, preempt
  );

  modport slave (
    input  req_m1, req_m2,
    output grant_m1, grant_m2, master_select, bus_busy, preempt
  );
endinterface

// File: rtl/bus_arbiter_hold_counter.sv
// Saturating ownership-hold counter: clear has priority over enable, and
// at_limit flags that the count has reached LIMIT.
module hold_counter #(
  parameter int CNT_WIDTH = 5,
  parameter int LIMIT     = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic at_limit
);

  localparam logic [CNT_WIDTH-1:0] LIMIT_V = CNT_WIDTH'(LIMIT);
  localparam logic [CNT_WIDTH-1:0] ONE_V   = CNT_WIDTH'(1);

  logic [CNT_WIDTH-1:0] cnt_q;
  logic [CNT_WIDTH-1:0] cnt_d;

  // Next count: clear, saturating increment, or hold.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && (cnt_q != LIMIT_V)) begin
      cnt_d = cnt_q + ONE_V;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign at_limit = (cnt_q == LIMIT_V);

endmodule

// File: rtl/bus_arbiter.sv
// Two-master bus arbiter with alternating tie-break, a one-cycle turnaround
// between owners and a hold limit that preempts an owner while the other waits.
module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter int MAX_HOLD  = DEFAULT_MAX_HOLD,
  parameter int CNT_WIDTH = DEFAULT_CNT_WIDTH
) (
  input  logic           clk,
  input  logic           rst,
  bus_arbiter_if.slave   bus
);

  logic [1:0] state_q, state_d;
  logic       last_owner_q, last_owner_d;
  logic       grant_m1_q, grant_m1_d;
  logic       grant_m2_q, grant_m2_d;
  logic       master_select_q, master_select_d;
  logic       bus_busy_q, bus_busy_d;
  logic       preempt_q, preempt_d;
  logic       own_now_s, own_next_s, hold_at_limit_s;

  assign own_now_s  = (state_q == ST_OWN_M1) || (state_q == ST_OWN_M2);
  assign own_next_s = (state_d == ST_OWN_M1) || (state_d == ST_OWN_M2);

  hold_counter #(
    .CNT_WIDTH (CNT_WIDTH),
    .LIMIT     (MAX_HOLD - 1)
  ) u_hold (
    .clk      (clk),
    .rst      (rst),
    .clr      (own_next_s && !own_now_s),
    .en       (own_now_s),
    .at_limit (hold_at_limit_s)
  );

  // Next-state and registered-output logic; a release wins over the hold limit.
  always_comb begin
    state_d   = state_q;
    preempt_d = 1'b0;
    case (state_q)
      ST_IDLE, ST_TURN: begin
        state_d = arbitrate(bus.req_m1, bus.req_m2, last_owner_q);
      end
      ST_OWN_M1: begin
        if (!bus.req_m1) begin
          state_d = ST_TURN;
        end else if (hold_at_limit_s && bus.req_m2) begin
          state_d   = ST_TURN;
          preempt_d = 1'b1;
        end else begin
          state_d = ST_OWN_M1;
        end
      end
      ST_OWN_M2: begin
        if (!bus.req_m2) begin
          state_d = ST_TURN;
        end else if (hold_at_limit_s && bus.req_m1) begin
          state_d   = ST_TURN;
          preempt_d = 1'b1;
        end else begin
          state_d = ST_OWN_M2;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    grant_m1_d = (state_d == ST_OWN_M1);
    grant_m2_d = (state_d == ST_OWN_M2);
    bus_busy_d = grant_m1_d || grant_m2_d;

    // Select and last owner only move when a grant rises.
    if (grant_m1_d) begin
      master_select_d = SEL_M1;
    end else if (grant_m2_d) begin
      master_select_d = SEL_M2;
    end else begin
      master_select_d = master_select_q;
    end
    last_owner_d = (own_next_s && !own_now_s) ? master_select_d : last_owner_q;
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= ST_IDLE;
      last_owner_q    <= SEL_M2;
      grant_m1_q      <= 1'b0;
      grant_m2_q      <= 1'b0;
      master_select_q <= SEL_M1;
      bus_busy_q      <= 1'b0;
      preempt_q       <= 1'b0;
    end else begin
      state_q         <= state_d;
      last_owner_q    <= last_owner_d;
      grant_m1_q      <= grant_m1_d;
      grant_m2_q      <= grant_m2_d;
      master_select_q <= master_select_d;
      bus_busy_q      <= bus_busy_d;
      preempt_q       <= preempt_d;
    end
  end

  assign bus.grant_m1      = grant_m1_q;
  assign bus.grant_m2      = grant_m2_q;
  assign bus.master_select = master_select_q;
  assign bus.bus_busy      = bus_busy_q;
  assign bus.preempt       = preempt_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed and random-request bench for bus_arbiter with a hold limit of 4.
module tb_bus_arbiter;
  import bus_arbiter_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  bus_arbiter_if bus_if ();

  bus_arbiter #(
    .MAX_HOLD  (4),
    .CNT_WIDTH (3)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  task automatic chk(input string tag, input logic got, input logic exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%b want=%b", tag, got, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic g1, input logic g2,
                         input logic sel, input logic busy, input logic pre);
    chk({tag, ".grant_m1"}, bus_if.grant_m1, g1);
    chk({tag, ".grant_m2"}, bus_if.grant_m2, g2);
    chk({tag, ".select"},   bus_if.master_select, sel);
    chk({tag, ".busy"},     bus_if.bus_busy, busy);
    chk({tag, ".preempt"},  bus_if.preempt, pre);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic p_r1, p_r2, p_g1, p_g2;

    rst = 1'b1;
    bus_if.req_m1 = 1'b0;
    bus_if.req_m2 = 1'b0;
    repeat (2) tick();
    chk_out("reset", 1'b0, 1'b0, SEL_M1, 1'b0, 1'b0);
    rst = 1'b0;

    // Single requester, one-cycle latency, then release through TURN.
    bus_if.req_m1 = 1'b1;
    #2;
    chk("lat_pre_edge", bus_if.grant_m1, 1'b0);
    tick();
    chk_out("m1_only", 1'b1, 1'b0, SEL_M1, 1'b1, 1'b0);
    bus_if.req_m1 = 1'b0;
    tick();
    chk_out("m1_turn", 1'b0, 1'b0, SEL_M1, 1'b0, 1'b0);
    tick();
    chk_out("m1_idle", 1'b0, 1'b0, SEL_M1, 1'b0, 1'b0);

    // Fresh reset, simultaneous request: master 1 wins, then master 2 after TURN.
    rst = 1'b1;
    #1;
    rst = 1'b0;
    bus_if.req_m1 = 1'b1;
    bus_if.req_m2 = 1'b1;
    tick();
    chk_out("tie_m1", 1'b1, 1'b0, SEL_M1, 1'b1, 1'b0);
    bus_if.req_m1 = 1'b0;
    tick();
    chk_out("tie_turn", 1'b0, 1'b0, SEL_M1, 1'b0, 1'b0);
    tick();
    chk_out("tie_m2", 1'b0, 1'b1, SEL_M2, 1'b1, 1'b0);
    bus_if.req_m2 = 1'b0;
    tick();
    chk_out("m2_turn", 1'b0, 1'b0, SEL_M2, 1'b0, 1'b0);
    tick();
    chk_out("idle_sel_hold", 1'b0, 1'b0, SEL_M2, 1'b0, 1'b0);

    // Hold limit: master 1 owns exactly 4 cycles while master 2 waits.
    bus_if.req_m1 = 1'b1;
    tick();
    chk_out("hold_c1", 1'b1, 1'b0, SEL_M1, 1'b1, 1'b0);
    bus_if.req_m2 = 1'b1;
    for (int i = 2; i <= 4; i++) begin
      tick();
      chk_out($sformatf("hold_c%0d", i), 1'b1, 1'b0, SEL_M1, 1'b1, 1'b0);
    end
    tick();
    chk_out("hold_preempt", 1'b0, 1'b0, SEL_M1, 1'b0, 1'b1);
    tick();
    chk_out("hold_m2", 1'b0, 1'b1, SEL_M2, 1'b1, 1'b0);

    // Release in the limit cycle counts as a release: no preempt.
    for (int i = 2; i <= 4; i++) begin
      tick();
      chk_out($sformatf("rel_c%0d", i), 1'b0, 1'b1, SEL_M2, 1'b1, 1'b0);
    end
    bus_if.req_m2 = 1'b0;
    tick();
    chk_out("rel_turn", 1'b0, 1'b0, SEL_M2, 1'b0, 1'b0);
    tick();
    chk_out("rel_m1", 1'b1, 1'b0, SEL_M1, 1'b1, 1'b0);

    // Saturated counter with no competitor keeps ownership.
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("sat_grant", bus_if.grant_m1, 1'b1);
      chk("sat_preempt", bus_if.preempt, 1'b0);
    end
    bus_if.req_m2 = 1'b1;
    tick();
    chk_out("sat_preempt_now", 1'b0, 1'b0, SEL_M1, 1'b0, 1'b1);
    tick();
    chk_out("sat_m2", 1'b0, 1'b1, SEL_M2, 1'b1, 1'b0);

    // Asynchronous reset in the middle of master 2 ownership.
    tick();
    chk_out("pre_rst_m2", 1'b0, 1'b1, SEL_M2, 1'b1, 1'b0);
    #3;
    rst = 1'b1;
    #1;
    chk_out("async_rst", 1'b0, 1'b0, SEL_M1, 1'b0, 1'b0);
    tick();
    rst = 1'b0;
    chk_out("rst_released", 1'b0, 1'b0, SEL_M1, 1'b0, 1'b0);
    tick();
    chk_out("post_rst_tie", 1'b1, 1'b0, SEL_M1, 1'b1, 1'b0);

    // Random requests: exclusivity, busy, and one-cycle grant latency.
    for (int i = 0; i < 10000; i++) begin
      if ($urandom_range(0, 7) == 0) bus_if.req_m1 = ~bus_if.req_m1;
      if ($urandom_range(0, 7) == 0) bus_if.req_m2 = ~bus_if.req_m2;
      p_r1 = bus_if.req_m1;
      p_r2 = bus_if.req_m2;
      p_g1 = bus_if.grant_m1;
      p_g2 = bus_if.grant_m2;
      tick();
      chk("rnd_exclusive", bus_if.grant_m1 & bus_if.grant_m2, 1'b0);
      chk("rnd_busy", bus_if.bus_busy, bus_if.grant_m1 | bus_if.grant_m2);
      if (!p_g1 && !p_g2 && (p_r1 || p_r2)) begin
        chk("rnd_latency", bus_if.grant_m1 | bus_if.grant_m2, 1'b1);
      end
      if (bus_if.grant_m1 && !p_g1) begin
        chk("rnd_req1_before", p_r1, 1'b1);
        chk("rnd_gap1", p_g2, 1'b0);
      end
      if (bus_if.grant_m2 && !p_g2) begin
        chk("rnd_req2_before", p_r2, 1'b1);
        chk("rnd_gap2", p_g1, 1'b0);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
